inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/riscv_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/inst_fetch.sv | 87 ++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants, FSM state encoding and PC helper for the fetch front end.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] pcPlus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, inst} buffer between fetch and decode; flush empties it in one cycle.
module fetch_fifo (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_flush,
    input  logic [63:0] i_data,
    output logic [63:0] o_data,
    output logic [1:0]  o_count
);

    logic [63:0] r_mem [0:1];
    logic        r_wrPtr;
    logic        r_rdPtr;
    logic [1:0]  r_count;

    // The caller guarantees push only when not full (or popping) and pop only when not empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wrPtr  <= 1'b0;
            r_rdPtr  <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, the BOOT/RUN FSM and fetch/redirect control.
module inst_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_pc,
    input  logic [31:0] i_inst,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_valid,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_inst,
    input  logic        i_id_ready
);

    fetch_state_t r_state;
    fetch_state_t w_stateNext;
    logic [31:0]  r_pc;
    logic [1:0]   w_count;
    logic [63:0]  w_head;
    logic         w_valid;
    logic         w_full;
    logic         w_pop;
    logic         w_fetch;

    assign w_valid = (w_count != 2'd0);
    assign w_full  = (w_count == 2'(DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Redirect overrides everything; a full buffer can still fetch when its head leaves.
    always_comb begin
        w_stateNext = r_state;
        w_pop       = 1'b0;
        w_fetch     = 1'b0;
        case (r_state)
            BOOT: begin
                w_stateNext = RUN;
            end
            RUN: begin
                w_stateNext = RUN;
                w_pop       = w_valid & i_id_ready & ~i_redirect;
                w_fetch     = ~i_redirect & (~w_full | (w_valid & i_id_ready));
            end
            default: begin
                w_stateNext = BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= i_redirect_pc & ~32'h3;
        end else if (w_fetch) begin
            r_pc <= pcPlus4(r_pc);
        end
    end

    fetch_fifo u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_fetch),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_data  ({r_pc, i_inst}),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign o_pc       = r_pc;
    assign o_if_valid = w_valid;
    assign o_if_pc    = w_valid ? w_head[63:32] : 32'h0000_0000;
    assign o_if_inst  = w_valid ? w_head[31:0]  : INST_NOP;

endmodule
